// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult
//  Purpose  : Sequential shift-and-add unsigned multiplier, FSM controller
//             plus accumulator/shift-register datapath. Optional macro
//             SHIFT_ADD_EARLY_TERM_EN ends CALC once the multiplier empties.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 calc_last;

    // Sum is 2W wide; (2^W-1)^2 always fits, so no carry-out is needed.
    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign acc_sum = acc_q + addend;

`ifdef SHIFT_ADD_EARLY_TERM_EN
    assign calc_last = (count_q == LAST_CNT) || ((mplier_q >> 1) == '0);
`else
    assign calc_last = (count_q == LAST_CNT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, A_in};
                    mplier_d = B_in;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (calc_last) begin
                    product_d = acc_sum;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decode registered state only, so they cannot glitch.
    assign busy    = (state_q == S_CALC);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult
//  Purpose  : Self-checking bench for shift_add_mult against an arithmetic
//             reference model (product = A*B, latency from multiplier bits).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_add_mult;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   A_in;
    logic [WIDTH-1:0]   B_in;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    shift_add_mult #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A_in    (A_in),
        .B_in    (B_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of CALC cycles an operation with multiplier b should take.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef SHIFT_ADD_EARLY_TERM_EN
        int msb = 0;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) msb = i;
        return msb + 1;
`else
        return WIDTH;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit noisy);
        int lat;
        logic [2*WIDTH-1:0] exp;
        lat   = exp_lat(b);
        exp   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j <= lat + 2; j++) begin
            if (noisy && j <= lat + 1) begin
                start = 1'($urandom);
                A_in  = WIDTH'($urandom);
                B_in  = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (j < lat) begin
                check("busy_calc", 32'(busy), 32'd1);
                check("done_calc", 32'(done), 32'd0);
            end else if (j == lat) begin
                check("busy_done", 32'(busy), 32'd0);
                check("done_pulse", 32'(done), 32'd1);
                check("product", 32'(product), 32'(exp));
            end else begin
                check("busy_after", 32'(busy), 32'd0);
                check("done_after", 32'(done), 32'd0);
                check("product_hold", 32'(product), 32'(exp));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int t1, t2, nd;
        rst_n = 1'b0;
        start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'd3, 4'd5, 1'b0);
        run_op(4'd15, 4'd15, 1'b0);
        run_op(4'd0, 4'd9, 1'b0);
        run_op(4'd7, 4'd1, 1'b0);
        run_op(4'd9, 4'd2, 1'b0);
        run_op(4'd5, 4'd8, 1'b0);
        run_op(4'd11, 4'd13, 1'b1);

        // Asynchronous reset during the second CALC cycle of 7*7.
        A_in  = 4'd7;
        B_in  = 4'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_done", 32'(done), 32'd0);
        run_op(4'd2, 4'd6, 1'b0);

        // Back-to-back with start held high: 1*1 then 4*4.
        A_in  = 4'd1;
        B_in  = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        A_in = 4'd4;
        B_in = 4'd4;
        t1 = -1;
        t2 = -1;
        nd = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    t1 = c;
                    check("b2b_prod1", 32'(product), 32'h01);
                end else begin
                    t2 = c;
                    check("b2b_prod2", 32'(product), 32'h10);
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_ndone", 32'(nd), 32'd2);
        check("b2b_first_lat", 32'(t1), 32'(exp_lat(4'd1)));
        check("b2b_spacing", 32'(t2 - t1), 32'(exp_lat(4'd4) + 2));
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 40; k++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential shift-and-add unsigned multiplier. It is the additive counterpart to the team's combinational 4-bit subtractor in the controller/datapath labs.
- The controller is an FSM. The datapath is an accumulator with an adder and shift registers.
- A single-cycle start pulse launches the operation; done pulses for one cycle when product is valid.
- Used by the lab top level as a multi-cycle ALU operation alongside add/sub.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A_in  input  WIDTH  multiplicand, unsigned.
- B_in  input  WIDTH  multiplier, unsigned.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse, product valid.
- product  output  2*WIDTH  result; holds until the next result.

Behaviour:
- Reset (rst_n low, asynchronous, any state, mid-operation included):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal acc, mcand, mplier and count all clear to 0.
  - An in-flight operation is discarded; there is no partial result.
- Internal registers:
  - acc[2W], mcand[2W], mplier[W].
  - count, $clog2(WIDTH) bits, minimum 1.
- IDLE:
  - start=1 at edge: mcand<={W'0,A_in}, mplier<=B_in, acc<=0, count<=0, go to CALC.
  - start=0: stay.
- CALC, every edge:
  - acc<=acc+(mplier[0] ? mcand : 0), computed at 2W width with no overflow possible.
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - Exit when count==WIDTH-1 (last bit processed). Go to DONE; product<=acc plus the final addend at that same edge.
  - start is ignored while in CALC and DONE; it is not queued.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge goes to IDLE unconditionally.
  - start asserted during DONE is ignored.
- Outputs:
  - busy and done are decoded from the registered state, so they are glitch-free.
  - product changes only on the CALC→DONE edge.
- Latency: start sampled at edge N, then CALC edges N+1..N+WIDTH, then done high in the cycle after edge N+WIDTH. Back-to-back throughput is one result per WIDTH+2 cycles.
- Operands: A_in and B_in are captured at the start edge only. Later changes have no effect on the operation in flight.
- Zero operands: the full WIDTH CALC cycles still run (without the optional feature); product=0.
- Max case: (2^W-1)^2 fits in 2W bits, e.g. 15*15=225=8'hE1.

Optional Feature:
- Macro: SHIFT_ADD_EARLY_TERM_EN.
- Defined: CALC also exits when the post-shift mplier (mplier>>1) is 0.
  - product is still correct, because the left-shift accumulation needs no final alignment.
  - Minimum of one CALC cycle. B_in=0 or 1 gives done in the cycle after edge N+1.
  - Latency in general = index of the highest set bit of B_in, plus 1 CALC cycle.
- Undefined: the exit condition is count only, giving a fixed WIDTH-cycle latency. The mplier-zero compare logic is absent.

Test Plan:
- Reset, then 3*5: start for 1 cycle → busy high for 4 cycles, done pulse 4 cycles after start edge, product=8'h0F. product holds after done falls.
- 15*15 → product=8'hE1. 0*9 → product=8'h00 after the full 4 CALC cycles (without the macro).
- Start pulses during CALC and DONE, with A_in/B_in changed mid-operation → ignored. Result matches the originally captured operands. No second done.
- rst_n low in the 2nd CALC cycle of 7*7 → immediately busy=0, done=0, product=0. A following 2*6 gives 8'h0C with normal latency.
- Back-to-back: start held high continuously with operands 1*1, then 4*4 → two done pulses 6 cycles apart (WIDTH+2); products 8'h01, then 8'h10.
- With SHIFT_ADD_EARLY_TERM_EN defined:
  - 7*1 → done after 1 CALC cycle, product=8'h07.
  - 9*2 → done after 2 CALC cycles, product=8'h12.
  - 5*8 → done after 4 CALC cycles, product=8'h28.
